// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART receiver feeding the program-text RAM write port.
// Byte pairs become {opcode, address} commands; cpu_hold keeps the core in reset while loading.
module uart_program_loader #(
  parameter int CLKS_PER_BIT      = 16,
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int TIMEOUT_CLKS      = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } ld_state_t;

  rx_state_t       rx_state;
  logic            rx_s1;
  logic            rx_s2;
  logic            rx_d;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            frame_err;
  logic            rx_start;

  ld_state_t       ld_state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] lo;
  logic [TW-1:0]   timer;
  logic            timed_out;

  assign rx_start  = (rx_state == RX_IDLE) && rx_d && !rx_s2;
  assign timed_out = (timer == TLAST) && !rx_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (rx_start) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            // a start bit that is high again at mid-bit was only a glitch
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL) begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state      <= IDLE;
      count         <= '0;
      lo            <= '0;
      timer         <= '0;
      program_write <= 1'b0;
      write_address <= '0;
      program_cmd   <= '0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      error         <= 1'b0;
    end else begin
      program_write <= 1'b0;
      load_done     <= 1'b0;
      timer <= (ld_state == IDLE || rx_start) ? '0 : timer + 1'b1;
      unique case (ld_state)
        IDLE: begin
          if (byte_valid && rx_byte == 8'h55) begin
            ld_state <= LO;
            count    <= '0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        LO: begin
          if (frame_err || timed_out) begin
            ld_state <= IDLE;
            error    <= 1'b1;
          end else if (byte_valid) begin
            lo       <= ADDR_WIDTH'(rx_byte);
            ld_state <= HI;
          end
        end
        HI: begin
          if (frame_err || timed_out) begin
            ld_state <= IDLE;
            error    <= 1'b1;
          end else if (byte_valid) begin
            if (rx_byte == 8'hFF) begin
              ld_state  <= IDLE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else if (rx_byte[7:4] != 4'h0) begin
              ld_state <= IDLE;
              error    <= 1'b1;
            end else if (!count[ADDR_WIDTH]) begin
              program_write <= 1'b1;
              write_address <= count[ADDR_WIDTH-1:0];
              program_cmd   <= DATA_WIDTH'({rx_byte[INSTRUCTION_WIDTH-1:0], lo});
              count         <= count + 1'b1;
              ld_state      <= LO;
            end else begin
              // full program: keep the session open so the end marker still lands
              error    <= 1'b1;
              ld_state <= LO;
            end
          end
        end
        default: ld_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: random and directed UART loads checked
// against a byte-level session model of the loader.
module tb_uart_program_loader;
  localparam int CPB   = 16;
  localparam int TMO   = 4096;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_line = 1'b1;
  logic sel = 1'b0;
  logic rx_a, rx_b;
  assign rx_a = sel ? 1'b1 : rx_line;
  assign rx_b = sel ? rx_line : 1'b1;

  logic pw_a, hold_a, done_a, err_a;
  logic [7:0] addr_a;
  logic [11:0] cmd_a;
  logic pw_b, hold_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [5:0] cmd_b;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .INSTRUCTION_WIDTH(4),
    .DATA_WIDTH(12), .TIMEOUT_CLKS(TMO)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a),
    .program_write(pw_a), .write_address(addr_a), .program_cmd(cmd_a),
    .cpu_hold(hold_a), .load_done(done_a), .error(err_a)
  );

  uart_program_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(2), .INSTRUCTION_WIDTH(4),
    .DATA_WIDTH(6), .TIMEOUT_CLKS(TMO)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b),
    .program_write(pw_b), .write_address(addr_b), .program_cmd(cmd_b),
    .cpu_hold(hold_b), .load_done(done_b), .error(err_b)
  );

  logic pw_m, hold_m, done_m, err_m;
  logic [7:0] addr_m;
  logic [11:0] cmd_m;
  assign pw_m   = sel ? pw_b : pw_a;
  assign hold_m = sel ? hold_b : hold_a;
  assign done_m = sel ? done_b : done_a;
  assign err_m  = sel ? err_b : err_a;
  assign addr_m = sel ? {6'b0, addr_b} : addr_a;
  assign cmd_m  = sel ? {6'b0, cmd_b} : cmd_a;

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int cmd;
  } wr_t;

  int n_assert = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int exp_done = 0;
  int obs_done = 0;
  int m_aw = 8;
  bit m_sess, m_hi, m_err, m_hold;
  int m_lo, m_count, m_last_addr, m_last_cmd;
  logic prev_pw = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_sess = 0; m_hi = 0; m_err = 0; m_hold = 0;
    m_lo = 0; m_count = 0; m_last_addr = 0; m_last_cmd = 0;
    exp_q.delete(); obs_q.delete();
    exp_done = 0; obs_done = 0;
  endfunction

  function automatic void model_abort();
    if (m_sess) begin
      m_sess = 0;
      m_err = 1;
    end
  endfunction

  function automatic void model_byte(input int b);
    if (!m_sess) begin
      if (b == 8'h55) begin
        m_sess = 1; m_hi = 0; m_count = 0; m_err = 0; m_hold = 1;
      end
    end else if (!m_hi) begin
      m_lo = b;
      m_hi = 1;
    end else begin
      m_hi = 0;
      if (b == 8'hFF) begin
        m_sess = 0; m_hold = 0; exp_done++;
      end else if (b >= 16) begin
        m_sess = 0; m_err = 1;
      end else if (m_count < (1 << m_aw)) begin
        m_last_addr = m_count;
        m_last_cmd = (b << m_aw) + (m_lo % (1 << m_aw));
        exp_q.push_back('{m_last_addr, m_last_cmd});
        m_count++;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (pw_m) begin
        chk("pw_one_cycle", {31'b0, prev_pw}, 32'd0);
        obs_q.push_back('{int'(addr_m), int'(cmd_m)});
      end
      if (done_m) begin
        chk("hold_falls_with_done", {31'b0, hold_m}, 32'd0);
        obs_done++;
      end
    end
    prev_pw = pw_m;
  end

  task automatic send_byte(input int b, input bit stop = 1'b1,
                           input int gap = -1);
    logic [7:0] bb;
    int g;
    bb = 8'(b);
    g = (gap < 0) ? int'($urandom_range(20, 0)) : gap;
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = bb[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    if (stop) model_byte(b);
    else model_abort();
    repeat (g) @(negedge clk);
    if (FRAME + g > TMO) model_abort();
  endtask

  task automatic send_pair(input int l, input int h);
    send_byte(l);
    send_byte(h);
  endtask

  task automatic check_state(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_waddr"}, obs_q[i].addr, exp_q[i].addr);
      chk({tag, "_wcmd"}, obs_q[i].cmd, exp_q[i].cmd);
    end
    chk({tag, "_done_cnt"}, obs_done, exp_done);
    chk({tag, "_error"}, {31'b0, err_m}, {31'b0, m_err});
    chk({tag, "_hold"}, {31'b0, hold_m}, {31'b0, m_hold});
    chk({tag, "_addr_held"}, {24'b0, addr_m}, m_last_addr);
    chk({tag, "_cmd_held"}, {20'b0, cmd_m}, m_last_cmd);
    chk({tag, "_pw_idle"}, {31'b0, pw_m}, 32'd0);
    exp_q.delete(); obs_q.delete();
    exp_done = 0; obs_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    do_reset();
    check_state("reset");

    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");

    send_byte(8'h55);
    send_pair(8'h03, 8'h07);
    send_pair(8'hFF, 8'h01);
    send_pair(8'h00, 8'hFF);
    check_state("basic");

    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34, 1'b0);
    check_state("frame_err");
    send_byte(8'h55);
    send_pair(8'h00, 8'hFF);
    check_state("recover");

    send_byte(8'h55);
    send_pair(8'h10, 8'h30);
    check_state("nibble");

    for (int i = 0; i < 3; i++) begin
      b = int'($urandom_range(255, 0));
      if (b == 8'h55) b = 8'h54;
      send_byte(b);
    end
    send_byte(8'h55);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send_pair(8'h55, 8'h02);
      else if (i == 6) begin
        send_byte(int'($urandom_range(255, 0)), 1'b1, TMO - 500);
        send_byte(int'($urandom_range(15, 0)));
      end else send_pair(int'($urandom_range(255, 0)),
                         int'($urandom_range(15, 0)));
    end
    send_pair(8'h00, 8'hFF);
    check_state("random");

    send_byte(8'h55);
    send_byte(8'h12, 1'b1, TMO + 50);
    check_state("timeout");
    send_pair(8'h03, 8'h07);
    check_state("post_timeout");

    send_byte(8'h55);
    send_pair(8'h01, 8'h02);
    send_pair(8'h03, 8'h04);
    send_pair(8'h05, 8'h40);
    check_state("pre_reset");
    rx_line = 1'b0;
    repeat (50) @(negedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pw", {31'b0, pw_a}, 32'd0);
    chk("rst_addr", {24'b0, addr_a}, 32'd0);
    chk("rst_cmd", {20'b0, cmd_a}, 32'd0);
    chk("rst_hold", {31'b0, hold_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_error", {31'b0, err_a}, 32'd0);
    do_reset();
    repeat (CPB * 12) @(negedge clk);
    check_state("after_reset");

    sel = 1'b1;
    m_aw = 2;
    do_reset();
    send_byte(8'h55);
    for (int i = 0; i < 5; i++)
      send_pair(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));
    send_pair(8'h00, 8'hFF);
    check_state("overflow");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
